// File: rtl/lwram_mem_bridge_if.sv
// Memory-controller side of the LWRAM bridge: one request/acknowledge channel.
// MEM_REQ is a level. MEM_A/D/BE/WE are held stable while it is high. The slave answers with a one-cycle MEM_ACK, and MEM_Q is valid only in that cycle.
interface lwram_mem_bridge_if #(
  parameter int ADDR_W = 19
);
  logic [ADDR_W-1:0] MEM_A;
  logic [15:0]       MEM_D;
  logic [1:0]        MEM_BE;
  logic              MEM_WE;
  logic              MEM_REQ;
  logic              MEM_ACK;
  logic [15:0]       MEM_Q;

  modport master (
    output MEM_A, MEM_D, MEM_BE, MEM_WE, MEM_REQ,
    input  MEM_ACK, MEM_Q
  );

  modport slave (
    input  MEM_A, MEM_D, MEM_BE, MEM_WE, MEM_REQ,
    output MEM_ACK, MEM_Q
  );
endinterface

// File: rtl/lwram_mem_bridge.sv
// Converts strobe-delimited SH-2 LWRAM accesses into single REQ/ACK memory transactions and holds WAIT_N low until each one completes.
// Optional macro LWRAM_WRPOST_EN adds a 1-entry posted-write buffer.
module lwram_mem_bridge #(
  parameter int ADDR_W          = 19,
  parameter bit WAIT_RELEASE_CE = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CE_R,
  input  logic              CE_F,
  input  logic [ADDR_W-1:0] A,
  input  logic [15:0]       DI,
  output logic [15:0]       DO,
  input  logic              DCE_N,
  input  logic              DOE_N,
  input  logic [1:0]        DWE_N,
  output logic              WAIT_N,
  lwram_mem_bridge_if.master mem,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2, S_REL = 2'd3} state_t;

`ifdef LWRAM_WRPOST_EN
  localparam bit WRPOST = 1'b1;
`else
  localparam bit WRPOST = 1'b0;
`endif

  state_t            state_q, state_d;
  logic              doe_n_q, dwe_all_q;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [15:0]       mem_d_q, mem_d_d, do_q, do_d;
  logic [1:0]        mem_be_q, mem_be_d;
  logic              mem_we_q, mem_we_d, mem_req_q, mem_req_d;
  logic              post_q, pend_q, pend_wr_q;
  logic              dwe_all, rd_start, wr_start, new_acc, strobe_idle;
  logic              issue, issue_wr, posting, wait_low;
  logic              unused_ce_r;

  assign unused_ce_r = CE_R;

  assign dwe_all     = &DWE_N;
  assign rd_start    = doe_n_q & ~DOE_N & ~DCE_N;
  assign wr_start    = dwe_all_q & ~dwe_all & ~DCE_N;
  assign new_acc     = rd_start | wr_start;
  assign strobe_idle = DCE_N | (DOE_N & dwe_all);
  // A pending access was held off by a buffer drain and is issued from the live bus.
  assign issue       = (state_q == S_IDLE) & (pend_q | new_acc);
  assign issue_wr    = pend_q ? pend_wr_q : wr_start;
  assign posting     = WRPOST & issue & ~pend_q & wr_start;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      doe_n_q   <= 1'b1;
      dwe_all_q <= 1'b1;
      mem_a_q   <= '0;
      mem_d_q   <= '0;
      mem_be_q  <= '0;
      mem_we_q  <= 1'b0;
      mem_req_q <= 1'b0;
      do_q      <= '0;
    end else begin
      state_q   <= state_d;
      doe_n_q   <= DOE_N;
      dwe_all_q <= dwe_all;
      mem_a_q   <= mem_a_d;
      mem_d_q   <= mem_d_d;
      mem_be_q  <= mem_be_d;
      mem_we_q  <= mem_we_d;
      mem_req_q <= mem_req_d;
      do_q      <= do_d;
    end
  end

`ifdef LWRAM_WRPOST_EN
  logic post_d, pend_d, pend_wr_d;

  always_comb begin
    post_d    = post_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    if (state_q == S_IDLE) begin
      post_d = posting;
      pend_d = 1'b0;
    end else begin
      if ((state_q == S_REQ) && mem.MEM_ACK) post_d = 1'b0;
      if (new_acc && !pend_q) begin
        pend_d    = 1'b1;
        pend_wr_d = wr_start;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      post_q    <= 1'b0;
      pend_q    <= 1'b0;
      pend_wr_q <= 1'b0;
    end else begin
      post_q    <= post_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
    end
  end
`else
  assign post_q    = 1'b0;
  assign pend_q    = 1'b0;
  assign pend_wr_q = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (issue) state_d = S_REQ;
      S_REQ: begin
        if (mem.MEM_ACK) begin
          if (post_q) state_d = (pend_q | new_acc) ? S_IDLE : S_REL;
          else        state_d = S_DONE;
        end
      end
      S_DONE: if (!WAIT_RELEASE_CE || CE_F) state_d = S_REL;
      // Waiting for the strobe to end stops one long strobe from re-triggering.
      S_REL:  if (strobe_idle || pend_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_a_d   = mem_a_q;
    mem_d_d   = mem_d_q;
    mem_be_d  = mem_be_q;
    mem_we_d  = mem_we_q;
    mem_req_d = mem_req_q;
    do_d      = do_q;
    wait_low  = 1'b0;
    case (state_q)
      S_IDLE: begin
        wait_low = pend_q | (new_acc & ~posting);
        if (issue) begin
          mem_a_d   = A;
          mem_req_d = 1'b1;
          mem_we_d  = issue_wr;
          if (issue_wr) begin
            mem_d_d  = DI;
            mem_be_d = ~DWE_N;
          end else begin
            mem_be_d = 2'b11;
          end
        end
      end
      S_REQ: begin
        wait_low = ~post_q | pend_q | new_acc;
        if (mem.MEM_ACK) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) do_d = mem.MEM_Q;
        end
      end
      S_DONE:  wait_low = 1'b1;
      S_REL:   wait_low = pend_q | (WRPOST & new_acc);
      default: wait_low = 1'b0;
    endcase
  end

  // Gated by reset so a strobe still low during reset cannot pull WAIT_N down.
  assign WAIT_N      = ~(wait_low & RST_N);
  assign DO          = do_q;
  assign mem.MEM_A   = mem_a_q;
  assign mem.MEM_D   = mem_d_q;
  assign mem.MEM_BE  = mem_be_q;
  assign mem.MEM_WE  = mem_we_q;
  assign mem.MEM_REQ = mem_req_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lwram_mem_bridge.sv
// Self-checking bench for lwram_mem_bridge: CPU strobe driver, memory-controller responder and a request/read-data scoreboard.
module tb_lwram_mem_bridge;
  localparam int AW = 19;
`ifdef LWRAM_WRPOST_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          CE_R = 1'b0, CE_F = 1'b0;
  logic [AW-1:0] A = '0;
  logic [15:0]   DI = '0;
  logic [15:0]   DO;
  logic          DCE_N = 1'b1, DOE_N = 1'b1;
  logic [1:0]    DWE_N = 2'b11;
  logic          WAIT_N;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;
  logic [15:0] last_do = 16'h0000;

  logic [37:0] exp_q[$];
  logic [15:0] exp_do_q[$];

  lwram_mem_bridge_if #(.ADDR_W(AW)) mif ();

  lwram_mem_bridge #(.ADDR_W(AW), .WAIT_RELEASE_CE(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F),
    .A(A), .DI(DI), .DO(DO),
    .DCE_N(DCE_N), .DOE_N(DOE_N), .DWE_N(DWE_N), .WAIT_N(WAIT_N),
    .mem(mif), .dbg_state_o(dbg_state)
  );

  // Clock, CPU clock-enable phases and REQ rising-edge monitor.
  always #5 CLK = ~CLK;

  initial begin
    logic [1:0] ce_cnt;
    ce_cnt = 2'd0;
    mif.MEM_ACK = 1'b0;
    mif.MEM_Q   = 16'h0000;
    forever begin
      @(posedge CLK); #1;
      cyc++;
      ce_cnt = ce_cnt + 2'd1;
      CE_F = (ce_cnt == 2'd3);
      CE_R = (ce_cnt == 2'd1);
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (mif.MEM_REQ === 1'b1 && !req_prev) req_rises++;
      req_prev = (mif.MEM_REQ === 1'b1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  // Drive one CPU access: chip enable first, then the read or write strobe.
  task automatic cpu_start(input bit wr, input logic [AW-1:0] a, input logic [15:0] di,
                           input logic [1:0] dwe, input logic exp_wait_n, input logic [15:0] rd_q);
    step();
    A = a; DI = di; DCE_N = 1'b0;
    if (wr) exp_q.push_back({1'b1, ~dwe, a, di});
    else begin
      exp_q.push_back({1'b0, 2'b11, a, 16'h0000});
      exp_do_q.push_back(rd_q);
    end
    step();
    if (wr) DWE_N = dwe; else DOE_N = 1'b0;
    smp();
    total++;
    if (WAIT_N !== exp_wait_n) begin
      bad++; $display("FAIL wait_detect: WAIT_N=%b expected %b", WAIT_N, exp_wait_n);
    end
    total++;
    if (mif.MEM_REQ !== 1'b0) begin
      bad++; $display("FAIL req_not_early: MEM_REQ=%b expected 0", mif.MEM_REQ);
    end
  endtask

  task automatic cpu_end();
    step();
    DOE_N = 1'b1; DWE_N = 2'b11; DCE_N = 1'b1;
    step(); step();
  endtask

  // Memory-controller responder: waits for REQ, checks it against the scoreboard, ACKs after lat cycles.
  task automatic serve(input int lat, input logic [15:0] q, input int rel_at, input int rd_at,
                       input int exp_wait, output int ack_cyc, output int req_cyc);
    bit got;
    int pre_high, wl;
    bit stable;
    logic [37:0] obs, snap, e;
    logic [15:0] ed;
    got = 1'b0; pre_high = 0; wl = 0; stable = 1'b1;
    ack_cyc = -1; req_cyc = -1;
    for (int t = 0; t < 20 && !got; t++) begin
      step(); smp();
      if (mif.MEM_REQ === 1'b1) got = 1'b1;
      else if (WAIT_N === 1'b1) pre_high++;
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL req_timeout: MEM_REQ=%b expected 1 within 20 cycles", mif.MEM_REQ);
      return;
    end
    req_cyc = cyc;
    total++;
    if (pre_high !== 0) begin
      bad++; $display("FAIL pre_req_wait: WAIT_N high %0d cycles before REQ, expected 0", pre_high);
    end
    obs = {mif.MEM_WE, mif.MEM_BE, mif.MEM_A, mif.MEM_WE ? mif.MEM_D : 16'h0000};
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 38'h0;
    total++;
    if (obs !== e) begin
      bad++; $display("FAIL req_fields: got we/be/a/d=%h expected %h", obs, e);
    end
    snap = {mif.MEM_WE, mif.MEM_BE, mif.MEM_A, mif.MEM_D};
    if (WAIT_N === 1'b0) wl++;
    for (int i = 1; i <= lat; i++) begin
      step();
      if (i == rel_at) begin DOE_N = 1'b1; DWE_N = 2'b11; end
      if (i == rd_at)  begin DWE_N = 2'b11; DOE_N = 1'b0; end
      if (i == lat)    begin mif.MEM_ACK = 1'b1; mif.MEM_Q = q; end
      smp();
      if (mif.MEM_REQ !== 1'b1 || {mif.MEM_WE, mif.MEM_BE, mif.MEM_A, mif.MEM_D} !== snap) stable = 1'b0;
      if (WAIT_N === 1'b0) wl++;
    end
    ack_cyc = cyc;
    step();
    mif.MEM_ACK = 1'b0; mif.MEM_Q = 16'($urandom);
    smp();
    total++;
    if (stable !== 1'b1) begin
      bad++; $display("FAIL req_stable: REQ or fields changed before ACK, expected stable");
    end
    total++;
    if (mif.MEM_REQ !== 1'b0) begin
      bad++; $display("FAIL req_drop: MEM_REQ=%b expected 0 after ACK", mif.MEM_REQ);
    end
    total++;
    if (wl !== exp_wait) begin
      bad++; $display("FAIL wait_window: WAIT_N low %0d cycles over REQ..ACK, expected %0d", wl, exp_wait);
    end
    if (!e[37]) begin
      ed = (exp_do_q.size() > 0) ? exp_do_q.pop_front() : 16'h0000;
      total++;
      if (DO !== ed) begin
        bad++; $display("FAIL read_do: DO=%h expected %h", DO, ed);
      end
      last_do = ed;
    end
  endtask

  // WAIT_N must stay low until the cycle after the first CE_F seen after ACK, then go high.
  task automatic wait_release(input bit posted);
    bit seen, ok, done;
    logic expv;
    seen = 1'b0; ok = 1'b1; done = 1'b0;
    for (int t = 0; t < 12 && !done; t++) begin
      expv = posted | seen;
      if (WAIT_N !== expv) ok = 1'b0;
      if (WAIT_N === 1'b1) done = 1'b1;
      else begin
        seen = seen | CE_F;
        step(); smp();
      end
    end
    total++;
    if (!ok || !done) begin
      bad++; $display("FAIL wait_release: WAIT_N=%b ok=%0d done=%0d expected release on CE_F", WAIT_N, ok, done);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      mif.MEM_ACK = i[0]; mif.MEM_Q = 16'hFFFF;
    end
    smp();
    total++; if (WAIT_N !== 1'b1) begin bad++; $display("FAIL rst_wait: WAIT_N=%b expected 1", WAIT_N); end
    total++; if (mif.MEM_REQ !== 1'b0) begin bad++; $display("FAIL rst_req: MEM_REQ=%b expected 0", mif.MEM_REQ); end
    total++; if (DO !== 16'h0000) begin bad++; $display("FAIL rst_do: DO=%h expected 0000", DO); end
    total++; if (mif.MEM_A !== 19'h0) begin bad++; $display("FAIL rst_a: MEM_A=%h expected 0", mif.MEM_A); end
    total++; if (mif.MEM_D !== 16'h0) begin bad++; $display("FAIL rst_d: MEM_D=%h expected 0", mif.MEM_D); end
    total++; if (mif.MEM_BE !== 2'b00) begin bad++; $display("FAIL rst_be: MEM_BE=%b expected 00", mif.MEM_BE); end
    total++; if (mif.MEM_WE !== 1'b0) begin bad++; $display("FAIL rst_we: MEM_WE=%b expected 0", mif.MEM_WE); end
    step();
    mif.MEM_ACK = 1'b0; RST_N = 1'b1;
    step(); step();
    mif.MEM_ACK = 1'b1; mif.MEM_Q = 16'h1111;
    step();
    mif.MEM_ACK = 1'b0;
    smp();
    total++; if (DO !== 16'h0000) begin bad++; $display("FAIL idle_ack_do: DO=%h expected 0000", DO); end
    total++; if (mif.MEM_REQ !== 1'b0) begin bad++; $display("FAIL idle_ack_req: MEM_REQ=%b expected 0", mif.MEM_REQ); end
  endtask

  task automatic test_read();
    int ac, rc, r0;
    r0 = req_rises;
    cpu_start(1'b0, 19'h12345, 16'h0000, 2'b11, 1'b0, 16'hBEEF);
    serve(4, 16'hBEEF, -1, -1, 5, ac, rc);
    wait_release(1'b0);
    cpu_end();
    total++;
    if (req_rises - r0 !== 1) begin bad++; $display("FAIL read_one_req: %0d REQs expected 1", req_rises - r0); end
  endtask

  task automatic test_byte_write();
    int ac, rc, r0;
    r0 = req_rises;
    cpu_start(1'b1, 19'h00010, 16'h00A5, 2'b10, POSTED, 16'h0000);
    serve(3, 16'h0000, -1, -1, POSTED ? 0 : 4, ac, rc);
    wait_release(POSTED);
    repeat (4) step();
    cpu_end();
    repeat (3) step();
    smp();
    total++;
    if (req_rises - r0 !== 1) begin bad++; $display("FAIL write_one_req: %0d REQs expected 1", req_rises - r0); end
    total++;
    if (DO !== last_do) begin bad++; $display("FAIL do_hold: DO=%h expected %h", DO, last_do); end
  endtask

  task automatic test_strobe_release();
    int ac, rc, r0;
    r0 = req_rises;
    cpu_start(1'b1, 19'h7ABCD, 16'h1357, 2'b00, POSTED, 16'h0000);
    serve(6, 16'h0000, 1, -1, POSTED ? 0 : 7, ac, rc);
    wait_release(POSTED);
    repeat (4) step();
    smp();
    total++;
    if (dbg_state !== 2'd0) begin bad++; $display("FAIL rel_idle: state=%0d expected 0", dbg_state); end
    total++;
    if (req_rises - r0 !== 1) begin bad++; $display("FAIL rel_one_req: %0d REQs expected 1", req_rises - r0); end
    cpu_end();
  endtask

  task automatic test_reset_mid();
    int ac, rc;
    step();
    A = 19'h30001; DCE_N = 1'b0;
    step();
    DOE_N = 1'b0;
    step(); smp();
    total++;
    if (mif.MEM_REQ !== 1'b1) begin bad++; $display("FAIL mid_req_up: MEM_REQ=%b expected 1", mif.MEM_REQ); end
    step(); step();
    RST_N = 1'b0;
    #1;
    total++; if (mif.MEM_REQ !== 1'b0) begin bad++; $display("FAIL mid_req_drop: MEM_REQ=%b expected 0", mif.MEM_REQ); end
    total++; if (WAIT_N !== 1'b1) begin bad++; $display("FAIL mid_wait: WAIT_N=%b expected 1", WAIT_N); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL mid_state: state=%0d expected 0", dbg_state); end
    DOE_N = 1'b1; DCE_N = 1'b1;
    step(); step();
    RST_N = 1'b1;
    step();
    cpu_start(1'b0, 19'h00ABC, 16'h0000, 2'b11, 1'b0, 16'h5A5A);
    serve(2, 16'h5A5A, -1, -1, 3, ac, rc);
    wait_release(1'b0);
    cpu_end();
  endtask

  task automatic test_back_to_back();
    int ac, rc, lat;
    logic [AW-1:0] a;
    logic [15:0] d;
    logic [1:0] dwe;
    for (int k = 0; k < 6; k++) begin
      a   = AW'($urandom_range(0, 32'h7FFFF));
      d   = 16'($urandom_range(0, 32'hFFFF));
      lat = $urandom_range(1, 5);
      if (k % 2 == 0) begin
        cpu_start(1'b0, a, 16'h0000, 2'b11, 1'b0, d);
        serve(lat, d, -1, -1, lat + 1, ac, rc);
        wait_release(1'b0);
      end else begin
        dwe = 2'($urandom_range(0, 2));
        cpu_start(1'b1, a, d, dwe, POSTED, 16'h0000);
        serve(lat, 16'h0000, -1, -1, POSTED ? 0 : lat + 1, ac, rc);
        wait_release(POSTED);
      end
      cpu_end();
    end
  endtask

`ifdef LWRAM_WRPOST_EN
  task automatic test_posted();
    int a1, r1, a2, r2;
    cpu_start(1'b1, 19'h00100, 16'hCAFE, 2'b00, 1'b1, 16'h0000);
    exp_q.push_back({1'b0, 2'b11, 19'h00100, 16'h0000});
    exp_do_q.push_back(16'h1234);
    serve(5, 16'h0000, -1, 1, 5, a1, r1);
    serve(5, 16'h1234, -1, -1, 6, a2, r2);
    total++;
    if (!(r2 > a1)) begin bad++; $display("FAIL post_order: read REQ cycle %0d expected after write ACK cycle %0d", r2, a1); end
    wait_release(1'b0);
    cpu_end();
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_byte_write();
    test_strobe_release();
    test_reset_mid();
    test_back_to_back();
`ifdef LWRAM_WRPOST_EN
    test_posted();
`endif
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL sb_drain: %0d requests left expected 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
